// File: rtl/vga_pkg.sv
// Shared VGA timing constants, cell-grid constants, capture FSM states and the
// RGB332 packing helper.
package vga_pkg;

  // 640x480@60 timing, counted in pixels (horizontal) and lines (vertical)
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  // One captured sample per DOWN x DOWN block of pixels
  localparam int VGA_DOWN = 8;
  localparam int CELLS_X  = 80;
  localparam int CELLS_Y  = 60;

  // Width of the pixel/line counters; both saturate at all-ones
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    ST_SEEK   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } vga_state_t;

  // Pack 24-bit colour into an RGB332 byte in the low bits of a word
  function automatic logic [31:0] rgb332(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    return {24'h0, r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Falling-edge detector for an active-low sync that is only meaningful on
// pix_en cycles. The previous level resets high so a low first sample counts
// as a fall.
module vga_edge_det (
  input  logic sysclk,
  input  logic reset_n,
  input  logic pix_en,
  input  logic sync_n,
  output logic fall
);

  logic prev_reg;

  // Remember the last level sampled on a pixel strobe
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg <= 1'b1;
    end else if (pix_en) begin
      prev_reg <= sync_n;
    end
  end

  assign fall = pix_en & ~sync_n & prev_reg;

endmodule

// File: rtl/vga_capture.sv
// Locks onto a VGA pixel stream, then writes one RGB332 sample per DOWN x DOWN
// cell of the active picture into data memory, one word per cell.
module vga_capture
  import vga_pkg::*;
#(
  parameter int          H_SYNC    = VGA_H_SYNC,
  parameter int          H_BP      = VGA_H_BP,
  parameter int          H_ACTIVE  = VGA_H_ACTIVE,
  parameter int          H_TOTAL   = VGA_H_TOTAL,
  parameter int          V_SYNC    = VGA_V_SYNC,
  parameter int          V_BP      = VGA_V_BP,
  parameter int          V_ACTIVE  = VGA_V_ACTIVE,
  parameter int          V_TOTAL   = VGA_V_TOTAL,
  parameter int          DOWN      = VGA_DOWN,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err
);

  // Active window bounds and cell geometry (grid is CELLS_X x CELLS_Y at defaults)
  localparam logic [31:0] X0     = 32'(H_SYNC + H_BP);
  localparam logic [31:0] X1     = 32'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [31:0] Y0     = 32'(V_SYNC + V_BP);
  localparam logic [31:0] Y1     = 32'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [31:0] DOWN_L = 32'(DOWN);
  localparam logic [31:0] HALF_L = 32'(DOWN / 2);
  localparam logic [31:0] GRID_X = 32'(H_ACTIVE / DOWN);
  localparam logic [31:0] GRID_Y = 32'(V_ACTIVE / DOWN);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             hs_fall, vs_fall;
  logic [CNT_W-1:0] hcount_reg, hcount_next;
  logic [CNT_W-1:0] vcount_reg, vcount_next;
  logic             vs_pend_reg;    // VS fell, line 0 starts at the next HS fall
  logic             skip_line_reg;  // first HS fall in TRACK may end a partial line
  logic             sync_err_reg;
  vga_state_t       state_reg, state_next;
  logic             line_err, frame_err;
  logic [31:0]      x_pos, y_pos, cell_x, cell_y;
  logic             capture;

  vga_edge_det u_hs_edge (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .pix_en  (pix_en),
    .sync_n  (vga_hs),
    .fall    (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .pix_en  (pix_en),
    .sync_n  (vga_vs),
    .fall    (vs_fall)
  );

  // Counts for the pixel being sampled now: hcount restarts on HS fall,
  // vcount restarts on the first HS fall at or after a VS fall
  always_comb begin
    hcount_next = hcount_reg;
    vcount_next = vcount_reg;
    if (hs_fall) begin
      hcount_next = '0;
    end else if (pix_en && hcount_reg != CNT_MAX) begin
      hcount_next = hcount_reg + 1'b1;
    end
    if (hs_fall) begin
      if (vs_fall || vs_pend_reg) begin
        vcount_next = '0;
      end else if (vcount_reg != CNT_MAX) begin
        vcount_next = vcount_reg + 1'b1;
      end
    end
  end

  // Timing checks use the count of the pixel before the fall
  always_comb begin
    line_err  = hs_fall && (hcount_reg != H_LAST) &&
                ((state_reg == ST_LOCKED) || (state_reg == ST_TRACK && !skip_line_reg));
    frame_err = vs_fall && (state_reg != ST_SEEK) && (vcount_reg != V_LAST);
  end

  // Lock FSM: next state and the locked flag
  always_comb begin
    state_next = state_reg;
    locked     = 1'b0;
    case (state_reg)
      ST_SEEK:   if (vs_fall) state_next = ST_TRACK;
      ST_TRACK:  begin
        if (line_err || frame_err) state_next = ST_SEEK;
        else if (vs_fall)          state_next = ST_LOCKED;
      end
      ST_LOCKED: if (line_err || frame_err) state_next = ST_SEEK;
      default:   state_next = ST_SEEK;
    endcase
    locked = (state_reg == ST_LOCKED);
  end

  // State, counters, sync bookkeeping and the sticky error flag
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_SEEK;
      hcount_reg    <= '0;
      vcount_reg    <= '0;
      vs_pend_reg   <= 1'b0;
      skip_line_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      if (line_err || frame_err) sync_err_reg <= 1'b1;
      if (hs_fall)      vs_pend_reg <= 1'b0;
      else if (vs_fall) vs_pend_reg <= 1'b1;
      if (state_reg == ST_SEEK && state_next == ST_TRACK) skip_line_reg <= 1'b1;
      else if (hs_fall && state_reg == ST_TRACK)          skip_line_reg <= 1'b0;
    end
  end

  // Sample-point decision; captures are dropped when lock is lost this cycle
  always_comb begin
    x_pos   = 32'(hcount_next) - X0;
    y_pos   = 32'(vcount_next) - Y0;
    cell_x  = x_pos / DOWN_L;
    cell_y  = y_pos / DOWN_L;
    capture = pix_en && (state_reg == ST_LOCKED) && (state_next == ST_LOCKED) &&
              (32'(hcount_next) >= X0) && (32'(hcount_next) < X1) &&
              (32'(vcount_next) >= Y0) && (32'(vcount_next) < Y1) &&
              ((x_pos % DOWN_L) == HALF_L) && ((y_pos % DOWN_L) == HALF_L);
  end

  // Memory write port; address/data hold between writes
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we     <= capture;
      frame_done <= capture && (cell_x == GRID_X - 1) && (cell_y == GRID_Y - 1);
      if (capture) begin
        mem_addr  <= BASE_ADDR + ((cell_y * GRID_X + cell_x) << 2);
        mem_wdata <= rgb332(vga_r, vga_g, vga_b);
      end
    end
  end

  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_vga_capture.sv
// Randomized scoreboard bench for vga_capture using a reduced raster so that
// whole frames fit in a short run. Stimulus pushes expected writes; a monitor
// pops and compares them whenever the DUT writes.
module tb_vga_capture;

  localparam int P_HSYNC = 4;
  localparam int P_HBP   = 4;
  localparam int P_HACT  = 32;
  localparam int P_HTOT  = 44;
  localparam int P_VSYNC = 2;
  localparam int P_VBP   = 2;
  localparam int P_VACT  = 16;
  localparam int P_VTOT  = 22;
  localparam int P_DOWN  = 8;
  localparam logic [31:0] P_BASE = 32'h0000_1000;
  localparam int GX = P_HACT / P_DOWN;
  localparam int GY = P_VACT / P_DOWN;
  localparam int X0 = P_HSYNC + P_HBP;
  localparam int Y0 = P_VSYNC + P_VBP;
  localparam int M_SEEK = 0, M_TRACK = 1, M_LOCKED = 2;

  logic        sysclk = 1'b0;
  logic        reset_n, pix_en;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;
  logic        mem_we, frame_done, locked, sync_err;
  logic [31:0] mem_addr, mem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    longint      cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  longint      cyc = 0;
  int          n_vec = 0, n_bad = 0;
  int          frame_writes = 0, frame_dones = 0;
  logic [31:0] done_addr, first_addr, first_data, last_addr, last_data;

  // Reference model state (frame/line level)
  int m_state, m_lines, m_prev_len;
  bit m_err, m_check;

  vga_capture #(
    .H_SYNC(P_HSYNC), .H_BP(P_HBP), .H_ACTIVE(P_HACT), .H_TOTAL(P_HTOT),
    .V_SYNC(P_VSYNC), .V_BP(P_VBP), .V_ACTIVE(P_VACT), .V_TOTAL(P_VTOT),
    .DOWN(P_DOWN), .BASE_ADDR(P_BASE)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_state = M_SEEK; m_err = 0; m_check = 0; m_lines = 0; m_prev_len = 0;
  endtask

  // A new line starts; first=1 means it is also the start of a frame (VS fall)
  task automatic model_line_start(input bit first);
    bit e;
    e = 0;
    if (m_state != M_SEEK) begin
      if (m_check && m_prev_len != P_HTOT) e = 1;
      if (first && m_lines != P_VTOT) e = 1;
    end
    if (e) begin
      m_state = M_SEEK; m_err = 1;
    end else if (first && m_state == M_SEEK) begin
      m_state = M_TRACK; m_check = 0;
    end else if (first && m_state == M_TRACK) begin
      m_state = M_LOCKED;
    end else if (!first && m_state != M_SEEK) begin
      m_check = 1;
    end
    if (first) m_lines = 1;
    else       m_lines++;
  endtask

  task automatic send_pixel(input logic hs, input logic vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    idle($urandom_range(0, 1));
    vga_hs = hs; vga_vs = vs; vga_r = r; vga_g = g; vga_b = b;
    pix_en = 1'b1;
    @(posedge sysclk);
    #1;
    pix_en = 1'b0;
  endtask

  // mode 0: red, 1: random colours, 2: random with pixel (4,4) = 12/34/56
  task automatic send_frame(input int n_lines, input int bad_line, input int bad_len,
                            input int mode, input int stop_v, input int stop_h);
    frame_writes = 0; frame_dones = 0;
    for (int v = 0; v < n_lines; v++) begin
      int len;
      len = (v == bad_line) ? bad_len : P_HTOT;
      for (int h = 0; h < len; h++) begin
        logic [7:0] r, g, b;
        int ax, ay, cx, cy;
        bit cap;
        exp_t e;
        ax = h - X0; ay = v - Y0;
        if (h == 0) model_line_start(v == 0);
        if (mode == 0) begin
          r = 8'hFF; g = 8'h00; b = 8'h00;
        end else begin
          r = 8'($urandom_range(0, 255));
          g = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          if (mode == 2 && ax == 4 && ay == 4) begin
            r = 8'h12; g = 8'h34; b = 8'h56;
          end
        end
        cap = (m_state == M_LOCKED) && ax >= 0 && ax < P_HACT && ay >= 0 && ay < P_VACT &&
              (ax % P_DOWN) == P_DOWN / 2 && (ay % P_DOWN) == P_DOWN / 2;
        cx = ax / P_DOWN; cy = ay / P_DOWN;
        send_pixel((h < P_HSYNC) ? 1'b0 : 1'b1, (v < P_VSYNC) ? 1'b0 : 1'b1, r, g, b);
        if (h == 0) begin
          check("locked_at_line", 32'(locked), 32'(m_state == M_LOCKED));
          check("sync_err_at_line", 32'(sync_err), 32'(m_err));
        end
        if (cap) begin
          e.addr = P_BASE + 32'(4 * (cy * GX + cx));
          e.data = {24'h0, r[7:5], g[7:5], b[7:6]};
          e.done = (cx == GX - 1) && (cy == GY - 1);
          e.cyc  = cyc;
          exp_q.push_back(e);
        end
        if (v == stop_v && h == stop_h) return;
      end
      m_prev_len = len;
    end
    idle(3);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    model_reset();
    idle(1);
  endtask

  // Monitor: every DUT write must match the next expected write
  always @(negedge sysclk) begin
    if (!reset_n) begin
      last_addr = '0; last_data = '0;
    end else if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_addr, mon_e.addr);
        check("wr_data", mem_wdata, mon_e.data);
        check("wr_frame_done", 32'(frame_done), 32'(mon_e.done));
        check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      if (frame_writes == 0) begin
        first_addr = mem_addr; first_data = mem_wdata;
      end
      frame_writes++;
      if (frame_done) begin
        frame_dones++; done_addr = mem_addr;
      end
      last_addr = mem_addr; last_data = mem_wdata;
    end else begin
      if (frame_done !== 1'b0) begin
        n_vec++; n_bad++;
        $display("FAIL done_without_we: got frame_done %b required 0", frame_done);
      end
      if (mem_addr !== last_addr || mem_wdata !== last_data) begin
        n_vec++; n_bad++;
        $display("FAIL hold: got addr %h data %h required %h %h", mem_addr, mem_wdata, last_addr, last_data);
      end
    end
  end

  initial begin
    reset_n = 1'b0; pix_en = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1;
    vga_r = '0; vga_g = '0; vga_b = '0;
    model_reset();
    idle(3);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Clean red frames: lock after two VS falls, then full cell grid per frame
    send_frame(P_VTOT, -1, 0, 0, -1, -1);
    check("f1_writes", 32'(frame_writes), 32'd0);
    check("f1_locked", 32'(locked), 32'd0);
    send_frame(P_VTOT, -1, 0, 0, -1, -1);
    check("f2_locked", 32'(locked), 32'd1);
    send_frame(P_VTOT, -1, 0, 0, -1, -1);
    check("f3_writes", 32'(frame_writes), 32'(GX * GY));
    check("f3_dones", 32'(frame_dones), 32'd1);
    check("f3_done_addr", done_addr, P_BASE + 32'(4 * (GX * GY - 1)));
    check("f3_data", first_data, 32'hE0);

    // Random colours, then the frame with pixel (4,4) = 12/34/56
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    send_frame(P_VTOT, -1, 0, 2, -1, -1);
    check("cell00_addr", first_addr, P_BASE);
    check("cell00_data", first_data, 32'h05);

    // One short line while locked
    send_frame(P_VTOT, 10, P_HTOT - 1, 1, -1, -1);
    check("badline_locked", 32'(locked), 32'd0);
    check("badline_err", 32'(sync_err), 32'd1);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_err_sticky", 32'(sync_err), 32'd1);

    // Short frame
    do_reset();
    check("rst2_sync_err", 32'(sync_err), 32'd0);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    send_frame(P_VTOT - 1, -1, 0, 1, -1, -1);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    check("shortframe_locked", 32'(locked), 32'd0);
    check("shortframe_err", 32'(sync_err), 32'd1);

    // Reset mid-frame right after cell (2,1) is captured
    do_reset();
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    send_frame(P_VTOT, -1, 0, 1, Y0 + P_DOWN + P_DOWN / 2, X0 + 2 * P_DOWN + P_DOWN / 2);
    idle(3);
    check("pre_reset_pending", 32'(exp_q.size()), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_mem_we", 32'(mem_we), 32'd0);
    check("async_mem_addr", mem_addr, 32'd0);
    check("async_mem_wdata", mem_wdata, 32'd0);
    check("async_frame_done", 32'(frame_done), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    check("async_sync_err", 32'(sync_err), 32'd0);
    idle(2);
    reset_n = 1'b1;
    model_reset();
    idle(1);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    check("post_rst_writes", 32'(frame_writes), 32'd0);
    check("post_rst_dones", 32'(frame_dones), 32'd0);
    send_frame(P_VTOT, -1, 0, 1, -1, -1);
    check("post_rst_relock_writes", 32'(frame_writes), 32'(GX * GY));

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
